alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Registered issue/retire stage wrapped around the combinational 32-bit ALU. It accepts operation commands over a valid/ready handshake and buffers them in a DEPTH-entry in-order FIFO. It drives the head command onto the ALU operand/select lines, then captures the ALU result and zero flag into a single output register, which downstream logic drains over a second valid/ready handshake.

## Interface
- DEPTH, 4, command FIFO entries; power of two, ≥2
- TAG_W, 4, width of the opaque per-command tag carried alongside each operation
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  command present
- in_ready  out  1  stage can accept; equals !fifo_full
- in_a  in  32  operand A
- in_b  in  32  operand B
- in_sel  in  4  ALU operation code, passed through unchanged
- in_tag  in  TAG_W  command tag
- in_fwd_a  in  1  use previous result as A (effective only with ALU_ISSUE_FWD_EN)
- alu_a  out  32  to ALU input A
- alu_b  out  32  to ALU input B
- alu_sel  out  4  to ALU select
- alu_out  in  32  ALU result
- alu_zero  in  1  ALU zero flag
- out_valid  out  1  result register holds a result
- out_ready  in  1  downstream accepts result
- out_result  out  32  captured result
- out_zero  out  1  captured zero flag
- out_tag  out  TAG_W  tag of captured result
- fifo_count  out  log2(DEPTH)+1  FIFO occupancy

## Operation
- Push: in_valid && in_ready at an edge writes {a, b, sel, tag, fwd_a} at the write pointer and advances it. Pointers wrap modulo DEPTH.
- A push is refused when the FIFO is full, even if a pop occurs in the same cycle. in_ready never depends on out_ready.
- ALU drive: when the FIFO is non-empty, alu_a/alu_b/alu_sel come combinationally from the head entry. When it is empty, all three are 0.
- Output slot is a two-state FSM:
  - SLOT_EMPTY → SLOT_FULL on issue.
  - SLOT_FULL → SLOT_EMPTY on out_valid && out_ready with no issue in the same cycle.
  - SLOT_FULL → SLOT_FULL on drain plus issue in the same cycle.
- Issue condition: FIFO non-empty && (slot empty || out_ready).
- On issue at an edge:
  - out_result ← alu_out
  - out_zero ← alu_zero
  - out_tag ← head tag
  - last_result ← alu_out
  - FIFO pops
- Simultaneous push and pop: occupancy unchanged; both pointers advance.
- Strict in-order retirement. No reordering, no dropping.
- The stage adds no arithmetic of its own. Division-by-zero and other operation semantics belong entirely to the ALU.

## Timing
- Reset (async assert, sync release by clk domain):
  - FIFO empty; fifo_count = 0
  - in_ready = 1
  - out_valid = 0
  - out_result = 0, out_zero = 0, out_tag = 0
  - last_result = 0
  - alu_a = 0, alu_b = 0, alu_sel = 0
- Reset mid-operation discards all queued and captured commands immediately.
- Latency: a command accepted at edge k into an empty FIFO with a free or draining slot is captured at edge k+1. out_valid is high during the cycle after edge k+1.
- Throughput: one result per cycle while out_ready stays high.
- out_result/out_zero/out_tag stay stable while out_valid && !out_ready.
- Total buffering is DEPTH + 1 commands (FIFO plus output slot).

## Configuration
- ALU_ISSUE_FWD_EN defined:
  - The fwd_a bit is stored per entry.
  - When the head's fwd_a = 1, alu_a = last_result (the result captured at the most recent issue) instead of the stored A.
  - After reset, last_result = 0.
- ALU_ISSUE_FWD_EN undefined:
  - in_fwd_a is ignored and not stored.
  - alu_a is always the stored A.
  - No last_result register exists.

## Test plan
- Single op: push sel=0000, A=5, B=7, tag=3 into an idle stage with out_ready=1. Expect out_valid one cycle after acceptance, with out_result=12, out_zero=0, out_tag=3.
- Zero flag: push sel=0001, A=9, B=9. Expect out_result=0, out_zero=1.
- Backpressure (DEPTH=4): hold out_ready=0 and push 6 commands. Expect:
  - 5 accepted; in_ready=0 once fifo_count=4; out_valid=1 holding the first result unchanged.
  - After out_ready=1, all 5 results retire in push order at one per cycle, and fifo_count returns to 0.
- Streaming: push 8 back-to-back adds (A=i, B=1) with out_ready=1. Expect results 1..8 on 8 consecutive cycles, with pointer wrap-around and no bubble.
- Forwarding (macro on): push add 3+4, then sel=0010, B=6, in_fwd_a=1 (in_a=99). Expect results 7, then 42. With the macro off, expect 7, then 594.
- Reset mid-flight: with 3 commands queued and out_valid=1, assert rst between edges. Expect out_valid=0, fifo_count=0, in_ready=1 immediately, and no stale result after release.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Registered issue/retire stage around an external combinational ALU: an in-order
// command FIFO feeding a one-entry result slot. `ALU_ISSUE_FWD_EN adds result forwarding into operand A.
module alu_issue_stage #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  input  logic [3:0]               in_sel,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic                     in_fwd_a,
  output logic [31:0]              alu_a,
  output logic [31:0]              alu_b,
  output logic [3:0]               alu_sel,
  input  logic [31:0]              alu_out,
  input  logic                     alu_zero,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic                     out_zero,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [3:0]       sel;
    logic [TAG_W-1:0] tag;
`ifdef ALU_ISSUE_FWD_EN
    logic             fwd;
`endif
  } cmd_t;

  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_t;

  cmd_t          mem [DEPTH];
  cmd_t          cmd_in;
  cmd_t          head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, issue;
  slot_t         slot_q, slot_d;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign in_ready = !full;
  // Push is gated only by full, so a same-cycle pop never frees a slot for it.
  assign push     = in_valid && !full;
  assign issue    = !empty && ((slot_q == SLOT_EMPTY) || out_ready);
  assign head     = mem[rd_ptr];
  assign out_valid  = (slot_q == SLOT_FULL);
  assign fifo_count = count;

  always_comb begin
    cmd_in     = '0;
    cmd_in.a   = in_a;
    cmd_in.b   = in_b;
    cmd_in.sel = in_sel;
    cmd_in.tag = in_tag;
`ifdef ALU_ISSUE_FWD_EN
    cmd_in.fwd = in_fwd_a;
`endif
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      case ({push, issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef ALU_ISSUE_FWD_EN
  logic [31:0] last_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        last_result <= '0;
    else if (issue) last_result <= alu_out;
  end
`else
  // in_fwd_a has no effect in this build.
  logic unused_fwd;
  assign unused_fwd = in_fwd_a;
`endif

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = '0;
    if (!empty) begin
      alu_a   = head.a;
      alu_b   = head.b;
      alu_sel = head.sel;
`ifdef ALU_ISSUE_FWD_EN
      if (head.fwd) alu_a = last_result;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) slot_q <= SLOT_EMPTY;
    else     slot_q <= slot_d;
  end

  always_comb begin
    slot_d = slot_q;
    case (slot_q)
      SLOT_EMPTY: if (issue) slot_d = SLOT_FULL;
      SLOT_FULL:  if (out_ready && !issue) slot_d = SLOT_EMPTY;
      default:    slot_d = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_result <= '0;
      out_zero   <= 1'b0;
      out_tag    <= '0;
    end else if (issue) begin
      out_result <= alu_out;
      out_zero   <= alu_zero;
      out_tag    <= head.tag;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus random traffic,
// scored against an in-order queue of results computed when each command is accepted.
module tb_alu_issue_stage;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
`ifdef ALU_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0, in_ready, in_fwd_a = 1'b0;
  logic [31:0]       in_a = '0, in_b = '0;
  logic [3:0]        in_sel = '0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic [31:0]       alu_a, alu_b, alu_out;
  logic [3:0]        alu_sel;
  logic              alu_zero;
  logic              out_valid, out_ready = 1'b0, out_zero;
  logic [31:0]       out_result;
  logic [TAG_W-1:0]  out_tag;
  logic [$clog2(DEPTH):0] fifo_count;

  always #5 clk = ~clk;

  alu_issue_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_tag(in_tag), .in_fwd_a(in_fwd_a),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_tag(out_tag), .fifo_count(fifo_count)
  );

  // Stand-in for the external ALU.
  function automatic logic [31:0] alu_f(logic [31:0] a, logic [31:0] b, logic [3:0] sel);
    case (sel)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a * b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      4'd6:    return a << b[4:0];
      4'd7:    return {31'd0, $signed(a) < $signed(b)};
      default: return a ^ ~b;
    endcase
  endfunction

  assign alu_out  = alu_f(alu_a, alu_b, alu_sel);
  assign alu_zero = (alu_out == 32'd0);

  typedef struct { logic [31:0] r; logic z; logic [TAG_W-1:0] t; } exp_t;
  exp_t        q[$];
  logic [31:0] model_last = '0;
  int          errors = 0, checks = 0, drains = 0;
  logic        hold_armed = 1'b0, last_drained = 1'b0;
  logic [31:0] h_res;
  logic        h_zero;
  logic [TAG_W-1:0] h_tag;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observe one cycle at the falling edge, then advance past the next rising edge.
  task automatic tick();
    exp_t e;
    logic [31:0] a_eff, r;
    @(negedge clk);
    if (hold_armed) begin
      chk("hold_result", out_result, h_res);
      chk("hold_zero", {31'd0, out_zero}, {31'd0, h_zero});
      chk("hold_tag", {28'd0, out_tag}, {28'd0, h_tag});
    end
    hold_armed = out_valid && !out_ready;
    h_res = out_result; h_zero = out_zero; h_tag = out_tag;
    last_drained = out_valid && out_ready;
    if (out_valid && out_ready) begin
      drains++;
      if (q.size() == 0) chk("no_pending_result", {31'd0, out_valid}, 32'd0);
      else begin
        e = q.pop_front();
        chk("result", out_result, e.r);
        chk("zero", {31'd0, out_zero}, {31'd0, e.z});
        chk("tag", {28'd0, out_tag}, {28'd0, e.t});
      end
    end
    if (in_valid && in_ready) begin
      a_eff = (FWD && in_fwd_a) ? model_last : in_a;
      r = alu_f(a_eff, in_b, in_sel);
      model_last = r;
      q.push_back('{r: r, z: (r == 32'd0), t: in_tag});
    end
    @(posedge clk); #1;
  endtask

  task automatic set_cmd(logic [31:0] a, logic [31:0] b, logic [3:0] sel, logic [3:0] tag, logic fwd);
    in_valid = 1'b1; in_a = a; in_b = b; in_sel = sel; in_tag = tag; in_fwd_a = fwd;
  endtask

  task automatic drain_all();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4 * DEPTH + 8 && (q.size() > 0 || out_valid); i++) tick();
    chk("drain_queue_empty", q.size(), 32'd0);
    chk("drain_fifo_count", {29'd0, fifo_count}, 32'd0);
  endtask

  initial begin
    int acc, d0, run, max_run;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    chk("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_zero", {31'd0, out_zero}, 32'd0);
    chk("rst_out_tag", {28'd0, out_tag}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_sel", {28'd0, alu_sel}, 32'd0);

    // Single op with latency
    out_ready = 1'b1;
    set_cmd(32'd5, 32'd7, 4'd0, 4'd3, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("lat_not_yet_valid", {31'd0, out_valid}, 32'd0);
    chk("head_alu_a", alu_a, 32'd5);
    chk("head_alu_b", alu_b, 32'd7);
    chk("head_count", {29'd0, fifo_count}, 32'd1);
    tick();
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("single_result", out_result, 32'd12);
    chk("single_zero", {31'd0, out_zero}, 32'd0);
    chk("single_tag", {28'd0, out_tag}, 32'd3);
    chk("empty_alu_a", alu_a, 32'd0);
    tick();

    // Zero flag
    set_cmd(32'd9, 32'd9, 4'd1, 4'd4, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    chk("zero_result", out_result, 32'd0);
    chk("zero_flag", {31'd0, out_zero}, 32'd1);
    drain_all();

    // Backpressure: DEPTH in FIFO plus one in the slot
    out_ready = 1'b0; acc = 0;
    for (int i = 0; i < 6; i++) begin
      set_cmd(32'd100 + i, i, 4'd0, 4'(i + 1), 1'b0);
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    chk("bp_accepted", acc, 32'd5);
    chk("bp_fifo_count", {29'd0, fifo_count}, 32'd4);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_first_result", out_result, 32'd100);
    tick();
    out_ready = 1'b1; d0 = drains;
    for (int i = 0; i < 5; i++) tick();
    chk("bp_drained", drains - d0, 32'd5);
    chk("bp_count_zero", {29'd0, fifo_count}, 32'd0);
    chk("bp_slot_empty", {31'd0, out_valid}, 32'd0);

    // Streaming with pointer wrap, no bubbles
    out_ready = 1'b1; d0 = drains; run = 0; max_run = 0;
    for (int t = 0; t < 14; t++) begin
      if (t < 8) set_cmd(t, 32'd1, 4'd0, 4'(t), 1'b0);
      else in_valid = 1'b0;
      tick();
      if (last_drained) begin run++; if (run > max_run) max_run = run; end
      else run = 0;
    end
    chk("stream_count", drains - d0, 32'd8);
    chk("stream_no_bubble", max_run, 32'd8);

    // Forwarding
    set_cmd(32'd3, 32'd4, 4'd0, 4'd5, 1'b0);
    tick();
    set_cmd(32'd99, 32'd6, 4'd2, 4'd6, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("fwd_first", out_result, 32'd7);
    tick();
    chk("fwd_second", out_result, FWD ? 32'd42 : 32'd594);
    chk("fwd_second_tag", {28'd0, out_tag}, 32'd6);
    drain_all();

    // Reset mid-flight
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_cmd(32'd20 + i, 32'd1, 4'd0, 4'(8 + i), 1'b0);
      tick();
    end
    in_valid = 1'b0;
    chk("mid_count", {29'd0, fifo_count}, 32'd3);
    chk("mid_valid", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_count", {29'd0, fifo_count}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    q.delete(); hold_armed = 1'b0; model_last = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_result", out_result, 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      in_a      = $urandom;
      in_b      = ($urandom_range(3) == 0) ? in_a : $urandom;
      in_sel    = 4'($urandom_range(15));
      in_tag    = 4'($urandom_range(15));
      in_fwd_a  = $urandom_range(1);
      tick();
    end
    drain_all();
    chk("final_valid", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
